// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU operations, ARM condition codes
// and operand forwarding selects.
package execute_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_ORR = 4'b0011,
      ALU_EOR = 4'b0100,
      ALU_MOV = 4'b0101
   } aluOp_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } condCode_t;

   typedef enum logic [1:0] {
      FWD_REG  = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10,
      FWD_RSVD = 2'b11
   } fwdSel_t;

endpackage

// File: rtl/execute_stage_cond_unit.sv
// Evaluates an ARM condition code against the current {N,Z,C,V} flags.
module cond_unit
   import execute_stage_pkg::*;
(
   input  logic [3:0] CondE,
   input  logic [3:0] FlagsE,
   output logic       CondExE
);

   logic n, z, c, v;

   assign {n, z, c, v} = FlagsE;

   // The reserved 1111 code falls through to the default and never executes
   always_comb begin
      CondExE = 1'b0;
      case (CondE)
         COND_EQ: CondExE = z;
         COND_NE: CondExE = ~z;
         COND_CS: CondExE = c;
         COND_CC: CondExE = ~c;
         COND_MI: CondExE = n;
         COND_PL: CondExE = ~n;
         COND_VS: CondExE = v;
         COND_VC: CondExE = ~v;
         COND_HI: CondExE = c & ~z;
         COND_LS: CondExE = ~c | z;
         COND_GE: CondExE = (n == v);
         COND_LT: CondExE = (n != v);
         COND_GT: CondExE = ~z & (n == v);
         COND_LE: CondExE = z | (n != v);
         COND_AL: CondExE = 1'b1;
         default: CondExE = 1'b0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: forwarding muxes, ALU, conditional flags register
// and the E-to-M pipeline register.
module execute_stage
   import execute_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        PCSrcE,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic        ALUSrcE,
   input  logic [1:0]  FlagWriteE,
   input  logic [3:0]  ALUControlE,
   input  logic [3:0]  CondE,
   input  logic [3:0]  RdE,
   input  logic [31:0] Rd1E,
   input  logic [31:0] Rd2E,
   input  logic [31:0] ExtE,
   input  logic [1:0]  ForwardAE,
   input  logic [1:0]  ForwardBE,
   input  logic [31:0] ResultW,
   output logic        PCSrcM,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic        MemWriteM,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM,
   output logic [3:0]  WA3M,
   output logic        BranchTakenE,
   output logic [3:0]  FlagsE
);

   logic [31:0] srcA, srcB, writeData, aluResult;
   logic [32:0] sum33;
   logic        aluC, aluV, validOp, condEx;
   logic [3:0]  flags, aluFlags;

   // Select 10 loops back our own registered result for back-to-back dependencies
   always_comb begin
      case (ForwardAE)
         FWD_W:   srcA = ResultW;
         FWD_M:   srcA = ALUResultM;
         default: srcA = Rd1E;
      endcase
      case (ForwardBE)
         FWD_W:   writeData = ResultW;
         FWD_M:   writeData = ALUResultM;
         default: writeData = Rd2E;
      endcase
      srcB = ALUSrcE ? ExtE : writeData;
   end

   // Subtraction is A + ~B + 1 so the carry-out is directly NOT borrow
   always_comb begin
      aluResult = '0;
      sum33     = '0;
      aluC      = 1'b0;
      aluV      = 1'b0;
      validOp   = 1'b1;
      case (ALUControlE)
         ALU_ADD: begin
            sum33     = {1'b0, srcA} + {1'b0, srcB};
            aluResult = sum33[31:0];
            aluC      = sum33[32];
            aluV      = (srcA[31] == srcB[31]) && (aluResult[31] != srcA[31]);
         end
         ALU_SUB: begin
            sum33     = {1'b0, srcA} + {1'b0, ~srcB} + 33'd1;
            aluResult = sum33[31:0];
            aluC      = sum33[32];
            aluV      = (srcA[31] != srcB[31]) && (aluResult[31] != srcA[31]);
         end
         ALU_AND: aluResult = srcA & srcB;
         ALU_ORR: aluResult = srcA | srcB;
         ALU_EOR: aluResult = srcA ^ srcB;
         ALU_MOV: aluResult = srcB;
         default: validOp = 1'b0;
      endcase
      aluFlags = {validOp & aluResult[31], validOp & (aluResult == 32'd0), aluC, aluV};
   end

   cond_unit u_cond (
      .CondE   (CondE),
      .FlagsE  (flags),
      .CondExE (condEx)
   );

   assign BranchTakenE = PCSrcE & condEx;
   assign FlagsE       = flags;

   // Flags are written at the edge, so the condition above always sees pre-update values
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else begin
         if (FlagWriteE[1] && condEx) flags[3:2] <= aluFlags[3:2];
         if (FlagWriteE[0] && condEx) flags[1:0] <= aluFlags[1:0];
      end
   end

   // Side-effect controls are gated by the condition; data fields always flow
   always_ff @(posedge clk) begin
      if (reset) begin
         PCSrcM     <= 1'b0;
         RegWriteM  <= 1'b0;
         MemtoRegM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         WA3M       <= '0;
      end else begin
         PCSrcM     <= PCSrcE & condEx;
         RegWriteM  <= RegWriteE & condEx;
         MemtoRegM  <= MemtoRegE;
         MemWriteM  <= MemWriteE & condEx;
         ALUResultM <= aluResult;
         WriteDataM <= writeData;
         WA3M       <= RdE;
      end
   end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have inputs PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, each 1 bit: E-stage control from the decode/execute register.
REQ-004 SHALL have input FlagWriteE, 2 bits: bit1 enables the N,Z write, bit0 enables the C,V write.
REQ-005 SHALL have inputs ALUControlE, 4 bits; CondE, 4 bits; RdE, 4 bits (destination register).
REQ-006 SHALL have inputs Rd1E, Rd2E, ExtE, each 32 bits: register operands and extended immediate.
REQ-007 SHALL have inputs ForwardAE and ForwardBE, each 2 bits: 00 selects the register value, 01 selects ResultW, 10 selects ALUResultM, 11 is reserved and treated as 00.
REQ-008 SHALL have input ResultW, 32 bits: writeback-stage result.
REQ-009 SHALL have outputs PCSrcM, RegWriteM, MemtoRegM, MemWriteM, each 1 bit, registered.
REQ-010 SHALL have outputs ALUResultM, WriteDataM, each 32 bits, and WA3M, 4 bits, all registered.
REQ-011 SHALL have output BranchTakenE, 1 bit, combinational: PCSrcE AND CondExE.
REQ-012 SHALL have output FlagsE, 4 bits {N,Z,C,V}: current flags register contents.

Function
REQ-013 SrcAE SHALL be the forwarded Rd1E, and WriteDataE SHALL be the forwarded Rd2E.
REQ-014 SrcBE SHALL be ExtE when ALUSrcE=1, otherwise WriteDataE.
REQ-015 ALUControlE encodings SHALL be:
- 0000: ADD.
- 0001: SUB (A-B).
- 0010: AND.
- 0011: ORR.
- 0100: EOR.
- 0101: MOV (B).
- Other codes: result 0, all four ALU flags 0.
REQ-016 N SHALL be result[31] and Z SHALL be (result==0).
REQ-017 C SHALL be the 33rd-bit carry-out for ADD, and NOT borrow for SUB.
REQ-018 V SHALL be signed overflow for ADD/SUB; C=V=0 for logic and MOV operations.
REQ-019 CondExE SHALL follow the standard ARM codes EQ..LE (0000-1101) evaluated on FlagsE; AL (1110) SHALL give 1; 1111 SHALL give 0.
REQ-020 The flags register SHALL update N,Z at the clock edge iff FlagWriteE[1] and CondExE; C,V likewise with FlagWriteE[0].
REQ-021 Condition evaluation SHALL use pre-update flags, so a flag-setting instruction never affects its own condition.
REQ-022 The E-to-M register SHALL have 1-cycle latency, no stall, and SHALL load every cycle.
REQ-023 PCSrcM, RegWriteM and MemWriteM SHALL load the E value ANDed with CondExE.
REQ-024 MemtoRegM, ALUResultM, WriteDataM and WA3M SHALL load unconditionally.
REQ-025 When the condition fails, all side effects (register write, memory write, PC redirect, flags) SHALL be suppressed, and data fields SHALL still propagate.
REQ-026 Forwarding select 10 SHALL use the current registered ALUResultM (internal loopback), giving back-to-back dependency without a stall.

Reset
REQ-027 On reset high at a clock edge, FlagsE and every M-stage output SHALL become 0.
REQ-028 Reset SHALL take priority over a simultaneous flag write or pipeline load.
REQ-029 Reset asserted mid-stream SHALL discard the in-flight E instruction with no flag update.
REQ-030 In the first cycle after reset, EQ SHALL evaluate false (Z=0).

Structure
REQ-031 A shared package SHALL define the ALUControl encodings, the condition-code encodings, and the forward-select encodings.
REQ-032 Condition evaluation SHALL live in sub-module cond_unit (inputs CondE and FlagsE, output CondExE).
REQ-033 The ALU, operand muxes, flags register and M register SHALL remain in execute_stage.

Verification
REQ-034 ADD 0x7FFFFFFF+1, AL, FlagWriteE=11 -> next cycle ALUResultM=0x80000000, FlagsE=1001.
REQ-035 SUB 5-5 with flags written, then next instruction EQ MemWriteE=1 -> MemWriteM=1; same with NE -> MemWriteM=0, ALUResultM still propagates.
REQ-036 Flag-setting instruction with CondE=0000 and Z=0 -> FlagsE unchanged, RegWriteM=0, BranchTakenE=0 even with PCSrcE=1.
REQ-037 ForwardAE=10 with ALUResultM=0x10, Rd1E=0, ADD ExtE=4 -> ALUResultM=0x14; ForwardBE=01 with ResultW=0xAB, ALUSrcE=0, MOV -> WriteDataM=0xAB.
REQ-038 Reset asserted in the same cycle as a flag-setting ADD -> FlagsE=0000 and all M outputs 0 next cycle.
REQ-039 CondE=1111 with RegWriteE=1 -> RegWriteM=0; CondE=1110 -> RegWriteM=1.
